// File: rtl/serial_add_seq_if.sv
// Bundles the operand/result handshake and the external full-adder cell hookup
// for serial_add_seq. The master side is whatever drives operands and hosts the cell.
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             fa_x;
    logic             fa_y;
    logic             fa_ci;
    logic             fa_s;
    logic             fa_co;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output start, a, b, cin, fa_s, fa_co,
        input  fa_x, fa_y, fa_ci, busy, done, sum, cout
    );

    modport slave (
        input  start, a, b, cin, fa_s, fa_co,
        output fa_x, fa_y, fa_ci, busy, done, sum, cout
    );
endinterface

// File: rtl/serial_add_seq.sv
// Bit-serial adder: shifts operands LSB-first through an external 1-bit full adder,
// one bit per cycle, and registers {cout,sum} when the last bit has been summed.
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_add_seq_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_psum;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic [WIDTH-1:0] w_psum_shift;

    assign w_psum_shift = {bus.fa_s, r_psum[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_next = RUN;
            RUN:     if (r_cnt == LAST) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Cell inputs come only from registers gated by state, so fa_s/fa_co never loop back.
    always_comb begin
        bus.busy  = 1'b0;
        bus.done  = 1'b0;
        bus.fa_x  = 1'b0;
        bus.fa_y  = 1'b0;
        bus.fa_ci = 1'b0;
        case (r_state)
            RUN: begin
                bus.busy  = 1'b1;
                bus.fa_x  = r_a[0];
                bus.fa_y  = r_b[0];
                bus.fa_ci = r_carry;
            end
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_psum  <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_carry <= bus.cin;
                        r_cnt   <= '0;
                        r_psum  <= '0;
                    end
                end
                RUN: begin
                    r_psum  <= w_psum_shift;
                    r_carry <= bus.fa_co;
                    r_a     <= {1'b0, r_a[WIDTH-1:1]};
                    r_b     <= {1'b0, r_b[WIDTH-1:1]};
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum  <= w_psum_shift;
                        r_cout <= bus.fa_co;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a behavioural full adder on the fa_* cell port.
module tb_serial_add_seq;
    localparam int W = 8;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    serial_add_seq_if #(.WIDTH(W)) bus ();

    serial_add_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.fa_s  = bus.fa_x ^ bus.fa_y ^ bus.fa_ci;
    assign bus.fa_co = (bus.fa_x & bus.fa_y) | (bus.fa_x & bus.fa_ci) | (bus.fa_y & bus.fa_ci);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one cycle, then watch 12 cycles; cycle 0 is the start cycle.
    task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         output int busy_n, output int done_at, output int done_n);
        busy_n  = 0;
        done_at = -1;
        done_n  = 0;
        bus.a     = ia;
        bus.b     = ib;
        bus.cin   = icin;
        bus.start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        bus.a = 8'hAA;
        bus.b = 8'h55;
        bus.cin = 1'b1;
        step();
        step();
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got=%b exp=0", bus.busy);
        end
        n_tests++;
        if (bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_done got=%b exp=0", bus.done);
        end
        n_tests++;
        if ({bus.cout, bus.sum} !== 9'h000) begin
            n_fail++;
            $display("FAIL reset_result got=%h exp=000", {bus.cout, bus.sum});
        end
        n_tests++;
        if ({bus.fa_x, bus.fa_y, bus.fa_ci} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_fa got=%b exp=000", {bus.fa_x, bus.fa_y, bus.fa_ci});
        end
        bus.start = 1'b0;
        rst = 1'b0;
        step();
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_busy got=%b exp=0", bus.busy);
        end
        $display("[TB] reset checked");
    endtask

    task automatic test_basic();
        logic [W-1:0] ea;
        logic [W-1:0] eb;
        logic         ec;
        int busy_n;
        int done_at;
        int done_n;
        ea = 8'h5A;
        eb = 8'h3C;
        ec = 1'b0;
        busy_n = 0;
        done_at = -1;
        done_n = 0;
        bus.a = ea;
        bus.b = eb;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) bus.start = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) begin
                done_n++;
                if (done_at < 0) done_at = k;
            end
            if (k >= 1 && k <= W) begin
                n_tests++;
                if ({bus.fa_x, bus.fa_y, bus.fa_ci} !== {ea[k-1], eb[k-1], ec}) begin
                    n_fail++;
                    $display("FAIL basic_fa_bit%0d got=%b exp=%b", k - 1,
                             {bus.fa_x, bus.fa_y, bus.fa_ci}, {ea[k-1], eb[k-1], ec});
                end
                ec = (ea[k-1] & eb[k-1]) | (ea[k-1] & ec) | (eb[k-1] & ec);
            end
        end
        n_tests++;
        if (busy_n != 8) begin
            n_fail++;
            $display("FAIL basic_busy_cycles got=%0d exp=8", busy_n);
        end
        n_tests++;
        if (done_at != 9 || done_n != 1) begin
            n_fail++;
            $display("FAIL basic_done got_cycle=%0d got_count=%0d exp_cycle=9 exp_count=1", done_at, done_n);
        end
        n_tests++;
        if ({bus.cout, bus.sum} !== {1'b0, 8'h96}) begin
            n_fail++;
            $display("FAIL basic_result got=%h exp=096", {bus.cout, bus.sum});
        end
        $display("[TB] 0x5A+0x3C+0 -> cout=%b sum=%h done@%0d", bus.cout, bus.sum, done_at);
    endtask

    task automatic test_carry();
        int busy_n;
        int done_at;
        int done_n;
        do_op(8'hFF, 8'h01, 1'b0, busy_n, done_at, done_n);
        n_tests++;
        if ({bus.cout, bus.sum} !== {1'b1, 8'h00} || done_n != 1) begin
            n_fail++;
            $display("FAIL carry_ff_01 got=%h dones=%0d exp=100 dones=1", {bus.cout, bus.sum}, done_n);
        end
        $display("[TB] 0xFF+0x01+0 -> cout=%b sum=%h", bus.cout, bus.sum);
        do_op(8'hFF, 8'hFF, 1'b1, busy_n, done_at, done_n);
        n_tests++;
        if ({bus.cout, bus.sum} !== {1'b1, 8'hFF} || done_n != 1) begin
            n_fail++;
            $display("FAIL carry_ff_ff_1 got=%h dones=%0d exp=1ff dones=1", {bus.cout, bus.sum}, done_n);
        end
        $display("[TB] 0xFF+0xFF+1 -> cout=%b sum=%h", bus.cout, bus.sum);
    endtask

    task automatic test_ignore_start();
        int done_n;
        done_n = 0;
        bus.a = 8'h10;
        bus.b = 8'h20;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) bus.start = 1'b0;
            if (k == 3) begin
                n_tests++;
                if ({bus.cout, bus.sum} !== {1'b1, 8'hFF}) begin
                    n_fail++;
                    $display("FAIL hold_during_run got=%h exp=1ff", {bus.cout, bus.sum});
                end
                bus.a = 8'h00;
                bus.b = 8'h00;
                bus.start = 1'b1;
            end
            if (k == 4) bus.start = 1'b0;
            if (bus.done) done_n++;
        end
        n_tests++;
        if ({bus.cout, bus.sum} !== {1'b0, 8'h30}) begin
            n_fail++;
            $display("FAIL ignore_start_result got=%h exp=030", {bus.cout, bus.sum});
        end
        n_tests++;
        if (done_n != 1) begin
            n_fail++;
            $display("FAIL ignore_start_dones got=%0d exp=1", done_n);
        end
        $display("[TB] 0x10+0x20 with start in RUN -> sum=%h dones=%0d", bus.sum, done_n);
    endtask

    task automatic test_reset_in_run();
        int done_n;
        int busy_n;
        int done_at;
        done_n = 0;
        bus.a = 8'h77;
        bus.b = 8'h11;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k == 1) bus.start = 1'b0;
            if (k == 4) rst = 1'b1;
            if (k == 5) begin
                rst = 1'b0;
                n_tests++;
                if (bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_busy got=%b exp=0", bus.busy);
                end
                n_tests++;
                if ({bus.cout, bus.sum} !== 9'h000) begin
                    n_fail++;
                    $display("FAIL abort_result got=%h exp=000", {bus.cout, bus.sum});
                end
            end
            if (bus.done) done_n++;
        end
        n_tests++;
        if (done_n != 0) begin
            n_fail++;
            $display("FAIL abort_dones got=%0d exp=0", done_n);
        end
        do_op(8'h01, 8'h02, 1'b0, busy_n, done_at, done_n);
        n_tests++;
        if ({bus.cout, bus.sum} !== {1'b0, 8'h03} || done_at != 9) begin
            n_fail++;
            $display("FAIL after_abort got=%h done@%0d exp=003 done@9", {bus.cout, bus.sum}, done_at);
        end
        $display("[TB] abort then 0x01+0x02 -> sum=%h", bus.sum);
    endtask

    task automatic test_back_to_back();
        int done_n;
        int last_done;
        int fa_bad;
        done_n = 0;
        last_done = 0;
        fa_bad = 0;
        bus.a = 8'h80;
        bus.b = 8'h80;
        bus.cin = 1'b0;
        bus.start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (!bus.busy && {bus.fa_x, bus.fa_y, bus.fa_ci} !== 3'b000) fa_bad++;
            if (bus.done) begin
                done_n++;
                n_tests++;
                if (k - last_done != (done_n == 1 ? 9 : 10) || {bus.cout, bus.sum} !== {1'b1, 8'h00}) begin
                    n_fail++;
                    $display("FAIL b2b_done%0d got_cycle=%0d got=%h exp_gap=%0d exp=100",
                             done_n, k, {bus.cout, bus.sum}, done_n == 1 ? 9 : 10);
                end
                last_done = k;
                $display("[TB] b2b done at cycle %0d sum=%h cout=%b", k, bus.sum, bus.cout);
            end
        end
        bus.start = 1'b0;
        n_tests++;
        if (done_n != 4) begin
            n_fail++;
            $display("FAIL b2b_dones got=%0d exp=4", done_n);
        end
        n_tests++;
        if (fa_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_fa_idle got=%0d nonzero cycles exp=0", fa_bad);
        end
        for (int k = 0; k < 3; k++) step();
        n_tests++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_release_busy got=%b exp=0", bus.busy);
        end
    endtask

    initial begin
        n_tests = 0;
        n_fail = 0;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        test_reset();
        test_basic();
        test_carry();
        test_ignore_start();
        test_reset_in_run();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
